// File: rtl/expr_string_tx_pkg.sv
// Shared constants for the ASCII arithmetic-expression stream: character codes,
// transmitter state encoding and the digit range also used by the recognizer.
package expr_string_tx_pkg;

   localparam logic [7:0] ASC_ZERO   = 8'h30;
   localparam logic [7:0] ASC_PLUS   = 8'h2B;
   localparam logic [7:0] ASC_MUL    = 8'h2A;
   localparam logic [7:0] ASC_DIG_LO = 8'h30;
   localparam logic [7:0] ASC_DIG_HI = 8'h39;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DIGIT = 2'd1;
   localparam logic [1:0] ST_OP    = 2'd2;

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
      return ASC_ZERO + {4'h0, d};
   endfunction

   function automatic logic [7:0] op_to_ascii(input logic plus);
      return plus ? ASC_PLUS : ASC_MUL;
   endfunction

endpackage

// File: rtl/expr_string_tx.sv
// Serialises one latched request (BCD digits + operator bits) into the ASCII
// byte stream digit (op digit)*, one byte per valid/ready handshake.
module expr_string_tx
   import expr_string_tx_pkg::*;
#(
   parameter int MAX_DIGITS = 8,
   parameter int CNT_W      = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    start,
   input  logic [CNT_W-1:0]        num_digits,
   input  logic [4*MAX_DIGITS-1:0] digits,
   input  logic [MAX_DIGITS-2:0]   ops,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    tx_last,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
   localparam int NSLOT = 2 ** IDX_W;

   logic [1:0]       state;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] idx_nxt;
   logic [CNT_W-1:0] nd_q;
   logic [3:0]       dig_q [NSLOT];
   logic             ops_q [NSLOT];
   logic             req_ok;
   logic             accept;
   logic             xfer;

   // Request qualification: only digits actually in use must be BCD.
   always_comb begin
      req_ok = (num_digits != '0) && (num_digits <= CNT_W'(MAX_DIGITS));
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if ((CNT_W'(i) < num_digits) && (digits[4*i +: 4] > 4'd9))
            req_ok = 1'b0;
      end
   end

   assign accept  = (state == ST_IDLE) && start && req_ok;
   assign xfer    = tx_valid && tx_ready;
   assign idx_nxt = idx + CNT_W'(1);

   // Request payload is data only; it is captured on acceptance and never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < MAX_DIGITS; i++)
            dig_q[i] <= digits[4*i +: 4];
         for (int i = 0; i < MAX_DIGITS - 1; i++)
            ops_q[i] <= ops[i];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= ST_IDLE;
         idx      <= '0;
         nd_q     <= '0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (!req_ok) begin
                     err <= 1'b1;
                  end else begin
                     state    <= ST_DIGIT;
                     idx      <= '0;
                     nd_q     <= num_digits;
                     busy     <= 1'b1;
                     tx_valid <= 1'b1;
                     tx_data  <= bcd_to_ascii(digits[3:0]);
                     tx_last  <= (num_digits == CNT_W'(1));
                  end
               end
            end
            ST_DIGIT: begin
               if (xfer) begin
                  if (tx_last) begin
                     state    <= ST_IDLE;
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state   <= ST_OP;
                     tx_data <= op_to_ascii(ops_q[idx[IDX_W-1:0]]);
                     tx_last <= 1'b0;
                  end
               end
            end
            ST_OP: begin
               if (xfer) begin
                  state   <= ST_DIGIT;
                  idx     <= idx_nxt;
                  tx_data <= bcd_to_ascii(dig_q[idx_nxt[IDX_W-1:0]]);
                  tx_last <= (idx_nxt == nd_q - CNT_W'(1));
               end
            end
            default: begin
               state    <= ST_IDLE;
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_expr_string_tx.sv
// Randomised bench for expr_string_tx: every request is turned into its expected
// ASCII string by a queue-based model and compared byte by byte at the sink.
module tb_expr_string_tx;

   localparam int MAX_DIGITS = 8;
   localparam int CNT_W      = 4;

   logic                    clk = 1'b0;
   logic                    clr = 1'b0;
   logic                    start = 1'b0;
   logic [CNT_W-1:0]        num_digits = '0;
   logic [4*MAX_DIGITS-1:0] digits = '0;
   logic [MAX_DIGITS-2:0]   ops = '0;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready = 1'b0;
   logic                    tx_last;
   logic                    busy;
   logic                    done;
   logic                    err;

   int checks = 0;
   int errors = 0;

   expr_string_tx #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .start(start), .num_digits(num_digits),
      .digits(digits), .ops(ops), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected stream straight from the expression grammar.
   function automatic bit model_ok(input int nd, input logic [31:0] dg);
      if (nd < 1 || nd > MAX_DIGITS) return 1'b0;
      for (int i = 0; i < nd; i++)
         if (dg[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   // rmode: 0 ready always, 1 random ready + stray starts, 2 ready pattern 1,0,0
   task automatic send(input int nd, input logic [31:0] dg, input logic [6:0] op,
                       input int rmode, input string nm);
      logic [7:0] exp_q[$];
      int         k;
      int         cyc;
      bit         fin;
      bit         stall;
      logic [7:0] pd;
      logic       pl;
      logic       rdy;
      bit         ok;
      logic [31:0] ndv;
      ok = model_ok(nd, dg);
      if (ok) begin
         for (int i = 0; i < nd; i++) begin
            exp_q.push_back(8'h30 + {4'h0, dg[4*i +: 4]});
            if (i < nd - 1) exp_q.push_back(op[i] ? 8'h2B : 8'h2A);
         end
      end
      ndv = nd;
      @(negedge clk);
      num_digits = ndv[CNT_W-1:0];
      digits     = dg;
      ops        = op;
      start      = 1'b1;
      tx_ready   = 1'b0;
      @(negedge clk);
      start      = 1'b0;
      digits     = $urandom;
      ops        = 7'($urandom);
      num_digits = 4'($urandom);
      if (!ok) begin
         check_eq({nm, "_err"}, {31'b0, err}, 32'd1);
         check_eq({nm, "_rej_valid"}, {31'b0, tx_valid}, 32'd0);
         check_eq({nm, "_rej_busy"}, {31'b0, busy}, 32'd0);
         check_eq({nm, "_rej_done"}, {31'b0, done}, 32'd0);
         @(negedge clk);
         check_eq({nm, "_err_pulse"}, {31'b0, err}, 32'd0);
         check_eq({nm, "_rej_valid2"}, {31'b0, tx_valid}, 32'd0);
         return;
      end
      check_eq({nm, "_first_valid"}, {31'b0, tx_valid}, 32'd1);
      check_eq({nm, "_no_err"}, {31'b0, err}, 32'd0);
      k = 0; cyc = 0; fin = 0; stall = 0; pd = '0; pl = 1'b0;
      while (!fin && cyc < 400) begin
         if (stall) begin
            check_eq({nm, "_hold_data"}, {24'b0, tx_data}, {24'b0, pd});
            check_eq({nm, "_hold_last"}, {31'b0, tx_last}, {31'b0, pl});
         end
         check_eq({nm, "_valid"}, {31'b0, tx_valid}, 32'd1);
         check_eq({nm, "_busy"}, {31'b0, busy}, 32'd1);
         check_eq({nm, "_early_done"}, {31'b0, done}, 32'd0);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom);
            default: rdy = (cyc % 3 == 0);
         endcase
         tx_ready = rdy;
         if (rdy) begin
            check_eq({nm, "_byte"}, {24'b0, tx_data}, {24'b0, exp_q[k]});
            check_eq({nm, "_last"}, {31'b0, tx_last}, {31'b0, k == exp_q.size() - 1});
            k++;
         end
         stall = !rdy;
         pd = tx_data;
         pl = tx_last;
         if (rmode == 1 && k < exp_q.size() && ($urandom % 4 == 0)) begin
            start      = 1'b1;
            num_digits = 4'd1;
            digits     = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (k == exp_q.size()) begin
            start = 1'b0;
            check_eq({nm, "_done"}, {31'b0, done}, 32'd1);
            check_eq({nm, "_end_busy"}, {31'b0, busy}, 32'd0);
            check_eq({nm, "_end_valid"}, {31'b0, tx_valid}, 32'd0);
            check_eq({nm, "_end_err"}, {31'b0, err}, 32'd0);
            fin = 1;
         end
      end
      start = 1'b0;
      if (!fin) check_eq({nm, "_timeout"}, 32'd0, 32'd1);
      if (rmode == 0) check_eq({nm, "_no_bubble"}, cyc, exp_q.size());
      @(negedge clk);
      check_eq({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   task automatic reset_mid_stream();
      logic [31:0] dg;
      logic [7:0]  exp_q[$];
      int          k;
      int          cyc;
      dg = 32'h8765_4321;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         exp_q.push_back(8'h30 + {4'h0, dg[4*i +: 4]});
         if (i < MAX_DIGITS - 1) exp_q.push_back(8'h2B);
      end
      @(negedge clk);
      num_digits = 4'd8; digits = dg; ops = 7'h7F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; cyc = 0;
      while (k < 5 && cyc < 50) begin
         tx_ready = 1'b1;
         check_eq("rst_byte", {24'b0, tx_data}, {24'b0, exp_q[k]});
         k++;
         if (k == 3) begin
            start = 1'b1; num_digits = 4'd1; digits = '0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq("rst_still_busy", {31'b0, busy}, 32'd1);
      #2 clr = 1'b0;
      #1;
      check_eq("rst_valid", {31'b0, tx_valid}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_data", {24'b0, tx_data}, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check_eq("rst_no_done", {31'b0, done}, 32'd0);
      check_eq("rst_idle_valid", {31'b0, tx_valid}, 32'd0);
   endtask

   initial begin
      int          nd;
      logic [31:0] dg;
      #3;
      check_eq("reset_valid", {31'b0, tx_valid}, 32'd0);
      check_eq("reset_busy", {31'b0, busy}, 32'd0);
      check_eq("reset_data", {24'b0, tx_data}, 32'h0);
      check_eq("reset_flags", {29'b0, tx_last, done, err}, 32'd0);
      @(negedge clk);
      clr = 1'b1;

      send(1, 32'h0000_0007, 7'b0, 0, "single");
      send(3, 32'h0000_0543, 7'b01, 0, "expr345");
      send(3, 32'h0000_0543, 7'b01, 2, "bp345");
      send(2, 32'h0000_00A0, 7'b0, 0, "rej_hex");
      send(0, 32'h0000_0000, 7'b0, 0, "rej_zero");
      send(9, 32'h1111_1111, 7'b0, 0, "rej_nine");
      send(2, 32'hFFFF_FF12, 7'b1, 0, "unused_hex");
      send(8, 32'h9876_5432, 7'h55, 0, "max_len");

      reset_mid_stream();
      send(4, 32'h0000_2468, 7'b101, 0, "after_rst");

      for (int t = 0; t < 30; t++) begin
         nd = $urandom_range(1, MAX_DIGITS);
         dg = '0;
         for (int i = 0; i < MAX_DIGITS; i++) dg[4*i +: 4] = 4'($urandom_range(0, 9));
         if ($urandom % 8 == 0) dg[4*$urandom_range(0, nd - 1) +: 4] = 4'($urandom_range(10, 15));
         send(nd, dg, 7'($urandom), $urandom_range(0, 2), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/expr_string_tx.md
Name: expr_string_tx

Overview:
- Transmitter side of the ASCII arithmetic-expression byte stream: digit (op digit)*, with op being '+' or '*'.
- Takes one parallel request (BCD digits plus operator bits) and serialises it into ASCII bytes, one byte per accepted handshake.
- Sits upstream of the expression-string recognizer, either in a loopback test harness or as the expression source for the calculator datapath.
- Every stream it emits is, by construction, accepted by the recognizer (out=1 after the final byte).

Parameters:
- MAX_DIGITS, 8: maximum operand digits per expression; stream length is at most 2*MAX_DIGITS-1 bytes.
- CNT_W, 4: width of num_digits and the internal index. Must satisfy 2^CNT_W > MAX_DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- num_digits  in  CNT_W  number of digits, valid range 1..MAX_DIGITS.
- digits  in  4*MAX_DIGITS  BCD digits; digit i sits at [4i+3:4i], and digit 0 is sent first.
- ops  in  MAX_DIGITS-1  operator i (sent between digit i and digit i+1): 1='+', 0='*'.
- tx_data  out  8  ASCII byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte.
- tx_last  out  1  marks the final byte of the expression; qualified by tx_valid.
- busy  out  1  a request is in progress.
- done  out  1  one-cycle pulse when the last byte transfers.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- All outputs are registered. While clr=0 (asynchronous): state=IDLE, tx_data=8'h00, and tx_valid, tx_last, busy, done, err are all 0.
- Transfer rule: a byte transfers on a rising clk edge when tx_valid && tx_ready.
- Hold rule: while tx_valid && !tx_ready, tx_data and tx_last stay stable.
- tx_valid never drops without a transfer, except on reset.
- States: IDLE, DIGIT, OP.
- IDLE, start=1, request invalid: invalid means num_digits==0, or num_digits>MAX_DIGITS, or any digit with index < num_digits is > 9. Response: err=1 next cycle, stay IDLE, no bytes emitted.
- IDLE, start=1, request valid: latch digits, ops and num_digits. Set idx=0 and busy=1. Next cycle enter DIGIT with tx_valid=1 and tx_data=8'h30+digits[idx]. Latency from start to first valid byte is 1 cycle.
- DIGIT: tx_last=1 iff idx==num_digits-1.
  - On transfer with tx_last=1: go IDLE; tx_valid=0, busy=0, done=1 for one cycle.
  - On transfer otherwise: go OP; tx_data = ops[idx] ? 8'h2B : 8'h2A; tx_last=0.
- OP: on transfer, idx<=idx+1, go DIGIT, tx_data=8'h30+digits[idx+1].
- Throughput: with tx_ready held at 1, the module emits one byte per cycle with no bubbles. A request of n digits produces 2n-1 bytes.
- start while busy is ignored and has no side effects. Input changes after a request is latched have no effect on the stream in progress.
- The next start is accepted in IDLE on the cycle after done, so there is one bubble between back-to-back expressions.
- Reset mid-stream: the stream is truncated immediately, with no done or err pulse. The module returns to IDLE.
- done and err are never asserted in the same cycle.

Decomposition:
- Shared package holds:
  - ASCII constants ASC_ZERO=8'h30, ASC_PLUS=8'h2B, ASC_MUL=8'h2A.
  - State encoding IDLE/DIGIT/OP.
  - Range constants ASC_DIG_LO=8'h30 and ASC_DIG_HI=8'h39, reused by the recognizer.
- No sub-module is required. Digit and operator selection is an indexed mux inside this block.

Test Plan:
- Single digit: num_digits=1, digits[3:0]=7, tx_ready=1. Expect exactly one byte 8'h37 with tx_last=1, then done=1 the following cycle; busy is high for exactly 1 cycle.
- "3+4*5": num_digits=3, digits=5,4,3 (idx2..0), ops=2'b01, tx_ready=1. Expect bytes 33, 2B, 34, 2A, 35 on consecutive cycles, tx_last only on 35. The recognizer fed the same bytes reads out=1 after 35.
- Backpressure: same request with tx_ready toggling 1,0,0,1,... Expect tx_data/tx_last held while stalled and the same 5 bytes in the same order, with no duplicates and no drops.
- Rejection: digits[7:4]=4'hA with num_digits=2 gives err=1 and no tx_valid. num_digits=0 gives err=1. num_digits=9 gives err=1.
- Reset and busy: start a MAX_DIGITS=8 request, pulse start again at byte 3 (ignored), then assert clr=0 at byte 5. Expect tx_valid=0 and busy=0 asynchronously and no done pulse. A new request afterwards streams correctly from digit 0.
